// File: rtl/seletor_jogador.sv
`default_nettype none
// ============================================================================
//  Module   : seletor_jogador
//  Brief    : Player-button conditioner. Synchronizes the five active-low
//             buttons, debounces single-button presses, validates the target
//             against the alive mask and latches the chosen player index
//             with a one-cycle confirmation pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seletor_jogador #(
  parameter int N_DEBOUNCE = 50000,
  parameter int W_CNT      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] botoes_n,
  input  logic [4:0] vivos,
  input  logic       habilita,
  input  logic       limpa,
  output logic [2:0] jogador_escolhido,
  output logic       escolha_valida,
  output logic       travado,
  output logic [2:0] db_estado
);

  // The counter is compared one step early so that the accepting edge is
  // also the edge on which it reaches N_DEBOUNCE-1; this gives exactly
  // N_DEBOUNCE cycles from a stable synchronized pattern to the pulse.
  localparam logic [W_CNT-1:0] c_CNT_ACEITA = W_CNT'(N_DEBOUNCE - 2);
  localparam logic [W_CNT-1:0] c_CNT_MAX    = {W_CNT{1'b1}};
  localparam logic [2:0]       c_NENHUM     = 3'b111;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    TRAVADO       = 3'd2,
    ESPERA_SOLTAR = 3'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [4:0]       sinc1_q;
  logic [4:0]       bs_q;
  logic [4:0]       padrao_q, padrao_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [2:0]       jog_q, jog_d;
  logic             valida_q, valida_d;
  logic             trav_q, trav_d;

  logic             w_unico;
  logic [2:0]       w_idx;
  logic             w_vivo;

  // Two-flop synchronizer for the inverted (active-high) button vector.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sinc1_q <= 5'd0;
      bs_q    <= 5'd0;
    end else begin
      sinc1_q <= ~botoes_n;
      bs_q    <= sinc1_q;
    end
  end

  // Exactly-one-bit test on the synchronized buttons.
  always_comb begin
    w_unico = (bs_q != 5'd0) && ((bs_q & (bs_q - 5'd1)) == 5'd0);
  end

  // Index and alive bit of the player held in the saved pattern.
  always_comb begin
    w_idx  = 3'd0;
    w_vivo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (padrao_q[i]) begin
        w_idx  = 3'(i);
        w_vivo = vivos[i];
      end
    end
  end

  // State, pattern, counter and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      padrao_q <= 5'd0;
      cnt_q    <= '0;
      jog_q    <= c_NENHUM;
      valida_q <= 1'b0;
      trav_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      padrao_q <= padrao_d;
      cnt_q    <= cnt_d;
      jog_q    <= jog_d;
      valida_q <= valida_d;
      trav_q   <= trav_d;
    end
  end

  // Next-state and output logic of the selection FSM.
  always_comb begin
    estado_d = estado_q;
    padrao_d = padrao_q;
    cnt_d    = cnt_q;
    jog_d    = jog_q;
    valida_d = 1'b0;
    trav_d   = trav_q;

    case (estado_q)
      OCIOSO: begin
        if (habilita && w_unico) begin
          padrao_d = bs_q;
          cnt_d    = '0;
          estado_d = FILTRANDO;
        end
      end

      FILTRANDO: begin
        if (!habilita) begin
          estado_d = OCIOSO;
        end else if (bs_q != padrao_q) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else if (cnt_q == c_CNT_ACEITA) begin
          cnt_d = cnt_q + 1'b1;
          if (w_vivo) begin
            jog_d    = w_idx;
            valida_d = 1'b1;
            trav_d   = 1'b1;
            estado_d = TRAVADO;
          end else begin
            estado_d = ESPERA_SOLTAR;
          end
        end else if (cnt_q != c_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      TRAVADO: begin
        if (limpa) begin
          jog_d    = c_NENHUM;
          trav_d   = 1'b0;
          estado_d = ESPERA_SOLTAR;
        end
      end

      ESPERA_SOLTAR: begin
        if (bs_q == 5'd0) begin
          estado_d = OCIOSO;
        end
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign jogador_escolhido = jog_q;
  assign escolha_valida    = valida_q;
  assign travado           = trav_q;
  assign db_estado         = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_seletor_jogador.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seletor_jogador
//  Brief    : Scoreboard bench for seletor_jogador with N_DEBOUNCE = 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seletor_jogador;

  localparam int N_DEB = 4;
  // raw edge -> 2 sync cycles -> N_DEB debounce cycles -> pulse
  localparam int LAT   = 2 + N_DEB;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] botoes_n;
  logic [4:0] vivos;
  logic       habilita;
  logic       limpa;
  logic [2:0] jogador_escolhido;
  logic       escolha_valida;
  logic       travado;
  logic [2:0] db_estado;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic prev_valida = 1'b0;

  typedef struct {
    int cyc;
    int idx;
  } exp_t;
  exp_t sb[$];

  seletor_jogador #(.N_DEBOUNCE(N_DEB), .W_CNT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .botoes_n          (botoes_n),
    .vivos             (vivos),
    .habilita          (habilita),
    .limpa             (limpa),
    .jogador_escolhido (jogador_escolhido),
    .escolha_valida    (escolha_valida),
    .travado           (travado),
    .db_estado         (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive a raw button pattern; if a pulse is expected, queue its cycle/index.
  task automatic press(input logic [4:0] pat, input int exp_idx);
    exp_t e;
    botoes_n = pat;
    if (exp_idx >= 0) begin
      e.cyc = cyc + LAT;
      e.idx = exp_idx;
      sb.push_back(e);
    end
  endtask

  task automatic clear_sel();
    botoes_n = 5'b11111;
    limpa    = 1'b1;
    tick(1);
    limpa    = 1'b0;
    tick(4);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (escolha_valida) begin
      exp_t e;
      check_eq("no_double_pulse", int'(prev_valida), 0);
      check_eq("pulse_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("pulse_cycle", cyc, e.cyc);
        check_eq("pulse_idx", int'(jogador_escolhido), e.idx);
      end
    end
    prev_valida <= escolha_valida;
  end

  initial begin
    reset    = 1'b0;
    botoes_n = 5'b00000;
    vivos    = 5'b11111;
    habilita = 1'b1;
    limpa    = 1'b0;
    tick(2);
    check_eq("rst_jog", int'(jogador_escolhido), 7);
    check_eq("rst_trav", int'(travado), 0);
    check_eq("rst_valida", int'(escolha_valida), 0);
    check_eq("rst_estado", int'(db_estado), 0);
    botoes_n = 5'b11111;
    reset    = 1'b1;
    tick(3);

    // clean press of player 2
    press(5'b11011, 2);
    tick(10);
    check_eq("clean_jog", int'(jogador_escolhido), 2);
    check_eq("clean_trav", int'(travado), 1);
    check_eq("clean_estado", int'(db_estado), 2);
    clear_sel();
    check_eq("clear_jog", int'(jogador_escolhido), 7);
    check_eq("clear_trav", int'(travado), 0);
    check_eq("clear_estado", int'(db_estado), 0);
    check_eq("clean_sb_empty", sb.size(), 0);

    // bouncing press of player 1
    press(5'b11101, -1);
    tick(2);
    press(5'b11111, -1);
    tick(1);
    press(5'b11101, 1);
    tick(10);
    check_eq("bounce_jog", int'(jogador_escolhido), 1);
    check_eq("bounce_sb_empty", sb.size(), 0);
    clear_sel();

    // multi-press is ignored
    press(5'b11100, -1);
    tick(10);
    check_eq("multi_estado", int'(db_estado), 0);
    check_eq("multi_jog", int'(jogador_escolhido), 7);
    press(5'b11111, -1);
    tick(3);

    // dead player is rejected and must be released
    vivos = 5'b01111;
    press(5'b01111, -1);
    tick(10);
    check_eq("dead_estado", int'(db_estado), 3);
    check_eq("dead_jog", int'(jogador_escolhido), 7);
    check_eq("dead_trav", int'(travado), 0);
    press(5'b11111, -1);
    tick(4);
    check_eq("dead_rel_estado", int'(db_estado), 0);
    vivos = 5'b11111;

    // hold, limpa with button held, no re-trigger, then new press
    press(5'b10111, 3);
    tick(10);
    check_eq("hold_jog", int'(jogador_escolhido), 3);
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    check_eq("limpa_jog", int'(jogador_escolhido), 7);
    check_eq("limpa_trav", int'(travado), 0);
    tick(10);
    check_eq("held_estado", int'(db_estado), 3);
    press(5'b11111, -1);
    tick(4);
    check_eq("held_rel_estado", int'(db_estado), 0);
    press(5'b11110, 0);
    tick(10);
    check_eq("p0_jog", int'(jogador_escolhido), 0);
    check_eq("p0_trav", int'(travado), 1);
    check_eq("p0_sb_empty", sb.size(), 0);
    clear_sel();

    // reset during FILTRANDO: no pulse may follow
    press(5'b11011, -1);
    tick(4);
    check_eq("filt_estado", int'(db_estado), 1);
    reset    = 1'b0;
    botoes_n = 5'b11111;
    tick(1);
    check_eq("rstf_jog", int'(jogador_escolhido), 7);
    check_eq("rstf_valida", int'(escolha_valida), 0);
    check_eq("rstf_estado", int'(db_estado), 0);
    reset = 1'b1;
    tick(8);

    // TRAVADO holds through habilita/vivos changes, then reset
    press(5'b01111, 4);
    tick(10);
    habilita = 1'b0;
    vivos    = 5'b00000;
    tick(3);
    check_eq("keep_jog", int'(jogador_escolhido), 4);
    check_eq("keep_trav", int'(travado), 1);
    reset = 1'b0;
    tick(1);
    check_eq("rstt_jog", int'(jogador_escolhido), 7);
    check_eq("rstt_trav", int'(travado), 0);
    check_eq("rstt_estado", int'(db_estado), 0);
    reset    = 1'b1;
    botoes_n = 5'b11111;
    habilita = 1'b1;
    vivos    = 5'b11111;
    tick(8);
    check_eq("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
